// File: rtl/lane_deskew_buffer.sv
// lane_deskew_buffer: removes per-lane channel skew before the data-link layer.
// Each lane pushes into its own FIFO. These pushes have no backpressure.
// A beat is released only when every lane holds a word. All lane words of that
// beat then leave together on one ready/valid output.
//
// Ports:
//   clk_i, rst_i     clock, asynchronous active-high reset
//   clear_i          synchronous flush of FIFOs, flags and state
//   lane_valid_i     per-lane push strobe
//   lane_data_i      per-lane push data, lane k at [k*LaneWidth +: LaneWidth]
//   data_o, valid_o  aligned beat (zero when not valid), ready_i pops it
//   overflow_o       sticky: push hit a full lane without a pop
//   skew_err_o       sticky: partial beat persisted longer than MaxSkew
//   state_o          00 IDLE, 01 ALIGN, 10 STREAM, 11 ERR
// Optional (macro LANE_DESKEW_SKEW_MONITOR_EN):
//   max_skew_o       largest skew count seen since reset/clear
//   beats_o          wrapping count of popped beats
module lane_deskew_buffer #(
    parameter int unsigned NumLanes  = 4,
    parameter int unsigned LaneWidth = 8,
    parameter int unsigned Depth     = 8,
    parameter int unsigned MaxSkew   = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          clear_i,
    input  logic [NumLanes-1:0]           lane_valid_i,
    input  logic [NumLanes*LaneWidth-1:0] lane_data_i,
    output logic [NumLanes*LaneWidth-1:0] data_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic                          overflow_o,
    output logic                          skew_err_o,
    output logic [1:0]                    state_o
`ifdef LANE_DESKEW_SKEW_MONITOR_EN
    ,
    output logic [7:0]                    max_skew_o,
    output logic [15:0]                   beats_o
`endif
);

    localparam int unsigned AW = $clog2(Depth);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned SW = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ALIGN  = 2'b01,
        STREAM = 2'b10,
        ERR    = 2'b11
    } state_t;

    state_t state_q, state_n;

    logic [LaneWidth-1:0] mem [NumLanes][Depth];
    logic [PW-1:0]        wr_ptr_q [NumLanes];
    logic [PW-1:0]        rd_ptr_q [NumLanes];
    logic [PW-1:0]        wr_ptr_n [NumLanes];
    logic [PW-1:0]        rd_ptr_n [NumLanes];

    logic [NumLanes-1:0]  empty_q, full_q, empty_n, push_en;
    logic                 all_ne_q, all_e_n, all_ne_n, partial_n;
    logic                 pop, block, overflow_evt, skew_evt;
    logic [SW-1:0]        skew_q, skew_n;
    logic                 overflow_q, skew_err_q;

    // Per-lane occupancy flags; wrap bit distinguishes full from empty
    always_comb begin
        for (int k = 0; k < NumLanes; k++) begin
            empty_q[k] = (wr_ptr_q[k] == rd_ptr_q[k]);
            full_q[k]  = (wr_ptr_q[k][AW] != rd_ptr_q[k][AW]) &&
                         (wr_ptr_q[k][AW-1:0] == rd_ptr_q[k][AW-1:0]);
        end
        all_ne_q = ~|empty_q;
    end

    // Push/pop qualification and next-cycle occupancy
    always_comb begin
        pop          = valid_o & ready_i;
        overflow_evt = (state_q != ERR) && !clear_i && !pop && |(lane_valid_i & full_q);
        block        = clear_i || overflow_evt || (state_q == ERR);
        push_en      = block ? '0 : lane_valid_i;
        for (int k = 0; k < NumLanes; k++) begin
            if (clear_i) begin
                wr_ptr_n[k] = '0;
                rd_ptr_n[k] = '0;
            end else begin
                wr_ptr_n[k] = wr_ptr_q[k] + PW'(push_en[k]);
                rd_ptr_n[k] = rd_ptr_q[k] + PW'(pop);
            end
            empty_n[k] = (wr_ptr_n[k] == rd_ptr_n[k]);
        end
        all_e_n   = &empty_n;
        all_ne_n  = ~|empty_n;
        partial_n = !all_e_n && !all_ne_n;
    end

    // Skew counter tracks the occupancy the next cycle will see, saturating
    always_comb begin
        skew_n = '0;
        if (!clear_i && partial_n)
            skew_n = (skew_q == {SW{1'b1}}) ? skew_q : skew_q + SW'(1);
        skew_evt = (state_q == ALIGN) && (skew_q > SW'(MaxSkew));
    end

    // FIFO pointers, skew counter and sticky flags
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < NumLanes; k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
            end
            skew_q     <= '0;
            overflow_q <= 1'b0;
            skew_err_q <= 1'b0;
        end else begin
            for (int k = 0; k < NumLanes; k++) begin
                wr_ptr_q[k] <= wr_ptr_n[k];
                rd_ptr_q[k] <= rd_ptr_n[k];
            end
            skew_q <= skew_n;
            if (clear_i) begin
                overflow_q <= 1'b0;
                skew_err_q <= 1'b0;
            end else begin
                if (overflow_evt)
                    overflow_q <= 1'b1;
                if (skew_evt && !overflow_evt)
                    skew_err_q <= 1'b1;
            end
        end
    end

    // FIFO storage, no reset needed since reads are gated by valid_o
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NumLanes; k++) begin
            if (push_en[k])
                mem[k][wr_ptr_q[k][AW-1:0]] <= lane_data_i[k*LaneWidth +: LaneWidth];
        end
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_n;
    end

    // Next state follows the occupancy the FIFOs will have after this edge,
    // so a beat is visible in the same cycle that the state reaches STREAM
    always_comb begin
        state_n = state_q;
        if (clear_i)
            state_n = IDLE;
        else if (state_q == ERR)
            state_n = ERR;
        else if (overflow_evt || skew_evt)
            state_n = ERR;
        else begin
            case (state_q)
                IDLE, ALIGN, STREAM: begin
                    if (all_e_n)       state_n = IDLE;
                    else if (all_ne_n) state_n = STREAM;
                    else               state_n = ALIGN;
                end
                default: state_n = ERR;
            endcase
        end
    end

    // Outputs, all derived from registered state
    always_comb begin
        valid_o = all_ne_q && ((state_q == ALIGN) || (state_q == STREAM));
        data_o  = '0;
        if (valid_o) begin
            for (int k = 0; k < NumLanes; k++)
                data_o[k*LaneWidth +: LaneWidth] = mem[k][rd_ptr_q[k][AW-1:0]];
        end
        state_o    = state_q;
        overflow_o = overflow_q;
        skew_err_o = skew_err_q;
    end

`ifdef LANE_DESKEW_SKEW_MONITOR_EN
    logic [SW-1:0] max_skew_q;
    logic [15:0]   beats_q;

    // Peak skew lags the counter by one cycle; beat counter wraps
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            max_skew_q <= '0;
            beats_q    <= '0;
        end else if (clear_i) begin
            max_skew_q <= '0;
            beats_q    <= '0;
        end else begin
            if (skew_q > max_skew_q)
                max_skew_q <= skew_q;
            beats_q <= beats_q + 16'(pop);
        end
    end

    assign max_skew_o = max_skew_q;
    assign beats_o    = beats_q;
`endif

endmodule

// File: tb/tb_lane_deskew_buffer.sv
// Directed bench for lane_deskew_buffer with hand-computed expectations.
module tb_lane_deskew_buffer;

    logic        clk;
    logic        rst;
    logic        clear;
    logic [3:0]  lane_valid;
    logic [31:0] lane_data;
    logic [31:0] data;
    logic        valid;
    logic        ready;
    logic        overflow;
    logic        skew_err;
    logic [1:0]  state;
`ifdef LANE_DESKEW_SKEW_MONITOR_EN
    logic [7:0]  max_skew;
    logic [15:0] beats;
`endif

    int checks = 0;
    int errors = 0;

    lane_deskew_buffer #(
        .NumLanes (4),
        .LaneWidth(8),
        .Depth    (8),
        .MaxSkew  (4)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .clear_i     (clear),
        .lane_valid_i(lane_valid),
        .lane_data_i (lane_data),
        .data_o      (data),
        .valid_o     (valid),
        .ready_i     (ready),
        .overflow_o  (overflow),
        .skew_err_o  (skew_err),
        .state_o     (state)
`ifdef LANE_DESKEW_SKEW_MONITOR_EN
        ,
        .max_skew_o  (max_skew),
        .beats_o     (beats)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b0;
        clear      = 1'b0;
        lane_valid = 4'h0;
        lane_data  = 32'h0;
        ready      = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_data", data, 32'h0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_skew", 32'(skew_err), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Aligned stream of three beats
        ready = 1'b1;
        lane_valid = 4'hF; lane_data = 32'h11111111;
        chk("al_c0_state", 32'(state), 32'd0);
        tick();
        chk("al_c1_valid", 32'(valid), 32'd1);
        chk("al_c1_data", data, 32'h11111111);
        chk("al_c1_state", 32'(state), 32'd2);
        lane_data = 32'h22222222;
        tick();
        chk("al_c2_data", data, 32'h22222222);
        lane_data = 32'h33333333;
        tick();
        chk("al_c3_valid", 32'(valid), 32'd1);
        chk("al_c3_data", data, 32'h33333333);
        lane_valid = 4'h0;
        tick();
        chk("al_c4_valid", 32'(valid), 32'd0);
        chk("al_c4_data", data, 32'h0);
        chk("al_c4_state", 32'(state), 32'd0);

        // Skew of three cycles, within the limit
        lane_valid = 4'h1; lane_data = 32'hA5A5A5A5;
        tick();
        lane_valid = 4'h0;
        chk("sk_c1_state", 32'(state), 32'd1);
        chk("sk_c1_valid", 32'(valid), 32'd0);
        tick();
        chk("sk_c2_state", 32'(state), 32'd1);
        tick();
        chk("sk_c3_state", 32'(state), 32'd1);
        lane_valid = 4'hE;
        tick();
        lane_valid = 4'h0;
        chk("sk_c4_valid", 32'(valid), 32'd1);
        chk("sk_c4_data", data, 32'hA5A5A5A5);
        chk("sk_c4_state", 32'(state), 32'd2);
        chk("sk_c4_err", 32'(skew_err), 32'd0);
        tick();
        chk("sk_c5_state", 32'(state), 32'd0);
`ifdef LANE_DESKEW_SKEW_MONITOR_EN
        chk("mon_max_skew", 32'(max_skew), 32'd3);
        chk("mon_beats", 32'(beats), 32'd4);
`endif

        // Skew error: only lane2 ever pushes
        lane_valid = 4'h4; lane_data = 32'h00C30000;
        tick();
        lane_valid = 4'h0;
        repeat (4) tick();
        chk("se_c5_state", 32'(state), 32'd1);
        chk("se_c5_err", 32'(skew_err), 32'd0);
        tick();
        chk("se_c6_state", 32'(state), 32'd3);
        chk("se_c6_err", 32'(skew_err), 32'd1);
        chk("se_c6_valid", 32'(valid), 32'd0);
        lane_valid = 4'hF; lane_data = 32'h12345678;
        tick();
        lane_valid = 4'h0;
        chk("se_c7_state", 32'(state), 32'd3);
        chk("se_c7_valid", 32'(valid), 32'd0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("se_clr_state", 32'(state), 32'd0);
        chk("se_clr_err", 32'(skew_err), 32'd0);
        chk("se_clr_ovf", 32'(overflow), 32'd0);
        chk("se_clr_valid", 32'(valid), 32'd0);
`ifdef LANE_DESKEW_SKEW_MONITOR_EN
        chk("mon_clr_max", 32'(max_skew), 32'd0);
`endif

        // Backpressure: fill all lanes to depth, then lane1 overflows
        ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            lane_valid = 4'hF;
            lane_data  = {8'(8'h30 + i), 8'(8'h20 + i), 8'(8'h10 + i), 8'(i)};
            tick();
        end
        chk("ov_full_valid", 32'(valid), 32'd1);
        chk("ov_full_data", data, 32'h30201000);
        chk("ov_full_state", 32'(state), 32'd2);
        chk("ov_full_ovf", 32'(overflow), 32'd0);
        lane_valid = 4'h2; lane_data = 32'h0000FF00;
        tick();
        lane_valid = 4'h0;
        chk("ov_ovf", 32'(overflow), 32'd1);
        chk("ov_state", 32'(state), 32'd3);
        chk("ov_valid", 32'(valid), 32'd0);
        chk("ov_data", data, 32'h0);
        chk("ov_skew", 32'(skew_err), 32'd0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("ov_clr_ovf", 32'(overflow), 32'd0);

        // Full lanes with simultaneous push and pop
        for (int i = 0; i < 8; i++) begin
            lane_valid = 4'hF;
            lane_data  = {4{8'(8'h40 + i)}};
            tick();
        end
        ready = 1'b1;
        lane_valid = 4'hF; lane_data = 32'h7E7E7E7E;
        tick();
        lane_valid = 4'h0;
        chk("fp_ovf", 32'(overflow), 32'd0);
        chk("fp_state", 32'(state), 32'd2);
        for (int j = 1; j < 8; j++) begin
            chk("fp_drain", data, {4{8'(8'h40 + j)}});
            tick();
        end
        chk("fp_last", data, 32'h7E7E7E7E);
        chk("fp_last_valid", 32'(valid), 32'd1);
        tick();
        chk("fp_empty_valid", 32'(valid), 32'd0);
        chk("fp_empty_state", 32'(state), 32'd0);

        // Asynchronous reset between clock edges with a beat pending
        ready = 1'b0;
        lane_valid = 4'hF; lane_data = 32'h5A5A5A5A;
        tick();
        lane_valid = 4'h0;
        chk("ar_pre_valid", 32'(valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("ar_valid", 32'(valid), 32'd0);
        chk("ar_state", 32'(state), 32'd0);
        chk("ar_data", data, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Normal operation resumes after reset
        ready = 1'b1;
        lane_valid = 4'hF; lane_data = 32'hC0C1C2C3;
        tick();
        lane_valid = 4'h0;
        chk("post_valid", 32'(valid), 32'd1);
        chk("post_data", data, 32'hC0C1C2C3);
        tick();
        chk("post_state", 32'(state), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
